// File: rtl/eth_pkt_gen_pkg.sv
// Shared types and helpers for the Ethernet TX packet generator.
package eth_pkt_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GAP     = 2'd3
    } state_e;

    localparam int HDR_WORDS     = 4;
    localparam int ETH_HDR_BYTES = 14;
    localparam int DEF_MIN_LEN   = 60;
    localparam int DEF_MAX_LEN   = 1514;

    // Number of 32-bit beats needed to carry len bytes.
    function automatic logic [8:0] calc_words(input logic [10:0] len);
        logic [11:0] t;
        t = {1'b0, len} + 12'd3;
        return t[10:2];
    endfunction

    // Unused byte lanes on the final beat: (4 - len%4) % 4.
    function automatic logic [1:0] calc_empty(input logic [10:0] len);
        return 2'd0 - len[1:0];
    endfunction

endpackage

// File: rtl/eth_pkt_gen_word_fmt.sv
// Combinational beat formatter: maps a word index to frame contents.
// Header words carry DA/SA/length; payload bytes count up from byte 16
// (right after the fixed 0x00 0x01 pair in word 3). Bytes past len are 0.
module eth_pkt_gen_word_fmt
    import eth_pkt_gen_pkg::*;
(
    input  logic [8:0]  word_idx,
    input  logic [11:0] byte_off,
    input  logic [47:0] da,
    input  logic [47:0] sa,
    input  logic [10:0] len,
    output logic [31:0] data,
    output logic        is_eop,
    output logic [1:0]  empty
);

    logic [15:0] len_field;
    logic [11:0] pos;
    logic [11:0] pay;

    // Select header word or build four payload bytes MSB-first.
    always_comb begin
        len_field = {5'd0, len} - 16'(ETH_HDR_BYTES);
        data      = '0;
        pos       = '0;
        pay       = '0;
        case (word_idx)
            9'd0:    data = da[47:16];
            9'd1:    data = {da[15:0], sa[47:32]};
            9'd2:    data = sa[31:0];
            9'd3:    data = {len_field, 8'h00, 8'h01};
            default: begin
                for (int j = 0; j < 4; j++) begin
                    pos = byte_off + 12'(j);
                    pay = pos - 12'(HDR_WORDS * 4);
                    if (pos < {1'b0, len}) begin
                        data[8*(3-j) +: 8] = pay[7:0];
                    end
                end
            end
        endcase
        is_eop = (word_idx == (calc_words(len) - 9'd1));
        empty  = is_eop ? calc_empty(len) : 2'd0;
    end

endmodule

// File: rtl/eth_tx_pkt_gen.sv
// Avalon-ST frame source for the 10G MAC TX client (32-bit, readyLatency 0).
// Frames carry DA, SA, length and an incrementing payload; the MAC adds FCS.
// Optional feature: define ETH_PKT_GEN_ERR_INJ_EN to flag every 8th frame
// with avalon_st_tx_error when inject_err is high.
// IPG_CYCLES must be at least 1.
module eth_tx_pkt_gen
    import eth_pkt_gen_pkg::*;
#(
    parameter int IPG_CYCLES = 4,
    parameter int MIN_LEN    = DEF_MIN_LEN,
    parameter int MAX_LEN    = DEF_MAX_LEN
) (
    input  logic        tx_156_25_clk,
    input  logic        tx_rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] pkt_count,
    input  logic [10:0] pkt_len,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic        inject_err,
    output logic        avalon_st_tx_startofpacket,
    output logic        avalon_st_tx_endofpacket,
    output logic        avalon_st_tx_valid,
    output logic [31:0] avalon_st_tx_data,
    output logic [1:0]  avalon_st_tx_empty,
    output logic        avalon_st_tx_error,
    input  logic        avalon_st_tx_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] sent_count
);

    state_e      state_q, state_d;
    logic [8:0]  word_q, word_d;
    logic [10:0] len_q, len_d;
    logic [47:0] da_q, da_d;
    logic [47:0] sa_q, sa_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] run_cnt_q, run_cnt_d;
    logic [31:0] sent_q, sent_d;
    logic        stop_seen_q, stop_seen_d;
    logic [15:0] gap_q, gap_d;
    logic        err_frame_q, err_frame_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  empty_q, empty_d;
    logic        error_q, error_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [10:0] len_clamp;
    logic [8:0]  fmt_idx;
    logic [10:0] fmt_len;
    logic [47:0] fmt_da;
    logic [47:0] fmt_sa;
    logic [31:0] fmt_data;
    logic        fmt_eop;
    logic [1:0]  fmt_empty;
    logic        accept;
    logic        run_end;
    logic        err_next;

`ifdef ETH_PKT_GEN_ERR_INJ_EN
    // Error is decided per frame from the count at that frame's sop.
    assign err_next = inject_err && (sent_q[2:0] == 3'b111);
`else
    logic unused_inject;
    assign err_next      = 1'b0;
    assign unused_inject = inject_err;
`endif

    assign len_clamp = (pkt_len < 11'(MIN_LEN)) ? 11'(MIN_LEN) :
                       (pkt_len > 11'(MAX_LEN)) ? 11'(MAX_LEN) : pkt_len;

    // In IDLE the first beat is built from live inputs since nothing is latched yet.
    assign fmt_len = (state_q == ST_IDLE) ? len_clamp : len_q;
    assign fmt_da  = (state_q == ST_IDLE) ? dst_mac   : da_q;
    assign fmt_sa  = (state_q == ST_IDLE) ? src_mac   : sa_q;
    assign fmt_idx = ((state_q == ST_IDLE) || (state_q == ST_GAP)) ? 9'd0 : (word_q + 9'd1);

    assign accept  = valid_q && avalon_st_tx_ready;
    assign run_end = stop_seen_q || stop ||
                     ((pkt_count_q != 32'd0) && (run_cnt_q == pkt_count_q));

    eth_pkt_gen_word_fmt u_fmt (
        .word_idx (fmt_idx),
        .byte_off ({1'b0, fmt_idx, 2'b00}),
        .da       (fmt_da),
        .sa       (fmt_sa),
        .len      (fmt_len),
        .data     (fmt_data),
        .is_eop   (fmt_eop),
        .empty    (fmt_empty)
    );

    // Next-state logic: beats only advance on acceptance, so outputs hold while !ready.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        len_d       = len_q;
        da_d        = da_q;
        sa_d        = sa_q;
        pkt_count_d = pkt_count_q;
        run_cnt_d   = run_cnt_q;
        sent_d      = sent_q;
        stop_seen_d = stop_seen_q;
        gap_d       = gap_q;
        err_frame_d = err_frame_q;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        data_d      = data_q;
        empty_d     = empty_q;
        error_d     = error_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    len_d       = len_clamp;
                    da_d        = dst_mac;
                    sa_d        = src_mac;
                    pkt_count_d = pkt_count;
                    run_cnt_d   = 32'd0;
                    stop_seen_d = 1'b0;
                    err_frame_d = err_next;
                    busy_d      = 1'b1;
                    word_d      = 9'd0;
                    valid_d     = 1'b1;
                    sop_d       = 1'b1;
                    data_d      = fmt_data;
                    eop_d       = fmt_eop;
                    empty_d     = fmt_empty;
                    error_d     = 1'b0;
                    state_d     = ST_HDR;
                end
            end
            ST_HDR, ST_PAYLOAD: begin
                if (stop) begin
                    stop_seen_d = 1'b1;
                end
                if (accept) begin
                    if (eop_q) begin
                        valid_d   = 1'b0;
                        sop_d     = 1'b0;
                        eop_d     = 1'b0;
                        empty_d   = 2'd0;
                        error_d   = 1'b0;
                        data_d    = 32'd0;
                        sent_d    = sent_q + 32'd1;
                        run_cnt_d = run_cnt_q + 32'd1;
                        gap_d     = 16'd0;
                        state_d   = ST_GAP;
                    end else begin
                        word_d  = fmt_idx;
                        sop_d   = 1'b0;
                        data_d  = fmt_data;
                        eop_d   = fmt_eop;
                        empty_d = fmt_empty;
                        error_d = fmt_eop && err_frame_q;
                        if ((state_q == ST_HDR) && (word_q == 9'(HDR_WORDS - 1))) begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    stop_seen_d = 1'b1;
                end
                if (gap_q == 16'(IPG_CYCLES - 1)) begin
                    if (run_end) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        word_d      = 9'd0;
                        err_frame_d = err_next;
                        valid_d     = 1'b1;
                        sop_d       = 1'b1;
                        data_d      = fmt_data;
                        eop_d       = fmt_eop;
                        empty_d     = fmt_empty;
                        error_d     = 1'b0;
                        state_d     = ST_HDR;
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge tx_156_25_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            len_q       <= '0;
            da_q        <= '0;
            sa_q        <= '0;
            pkt_count_q <= '0;
            run_cnt_q   <= '0;
            sent_q      <= '0;
            stop_seen_q <= 1'b0;
            gap_q       <= '0;
            err_frame_q <= 1'b0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            data_q      <= '0;
            empty_q     <= '0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            len_q       <= len_d;
            da_q        <= da_d;
            sa_q        <= sa_d;
            pkt_count_q <= pkt_count_d;
            run_cnt_q   <= run_cnt_d;
            sent_q      <= sent_d;
            stop_seen_q <= stop_seen_d;
            gap_q       <= gap_d;
            err_frame_q <= err_frame_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            data_q      <= data_d;
            empty_q     <= empty_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign avalon_st_tx_startofpacket = sop_q;
    assign avalon_st_tx_endofpacket   = eop_q;
    assign avalon_st_tx_valid         = valid_q;
    assign avalon_st_tx_data          = data_q;
    assign avalon_st_tx_empty         = empty_q;
    assign avalon_st_tx_error         = error_q;
    assign busy                       = busy_q;
    assign done                       = done_q;
    assign sent_count                 = sent_q;

endmodule

// File: tb/tb_eth_tx_pkt_gen.sv
// Self-checking bench for eth_tx_pkt_gen: a byte-level frame model drives
// expectations for every beat, the inter-frame gap and run completion.
module tb_eth_tx_pkt_gen;

    localparam int IPG = 4;
`ifdef ETH_PKT_GEN_ERR_INJ_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, inject_err, ready;
    logic [31:0] pkt_count;
    logic [10:0] pkt_len;
    logic [47:0] dst_mac, src_mac;
    logic        sop, eop, valid, error, busy, done;
    logic [31:0] data, sent_count;
    logic [1:0]  empty;

    int vecs = 0;
    int miscompares = 0;
    int m_sent = 0;
    int err_eops = 0;
    int r_len;
    logic [47:0] r_da, r_sa;
    bit r_inj;

    eth_tx_pkt_gen #(.IPG_CYCLES(IPG)) dut (
        .tx_156_25_clk              (clk),
        .tx_rst_n                   (rst_n),
        .start                      (start),
        .stop                       (stop),
        .pkt_count                  (pkt_count),
        .pkt_len                    (pkt_len),
        .dst_mac                    (dst_mac),
        .src_mac                    (src_mac),
        .inject_err                 (inject_err),
        .avalon_st_tx_startofpacket (sop),
        .avalon_st_tx_endofpacket   (eop),
        .avalon_st_tx_valid         (valid),
        .avalon_st_tx_data          (data),
        .avalon_st_tx_empty         (empty),
        .avalon_st_tx_error         (error),
        .avalon_st_tx_ready         (ready),
        .busy                       (busy),
        .done                       (done),
        .sent_count                 (sent_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vecs++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Byte p of the frame as laid out on the wire (before FCS).
    function automatic logic [7:0] frame_byte(input int p);
        logic [15:0] lt;
        lt = 16'(r_len - 14);
        if (p < 6)        return r_da[8*(5-p) +: 8];
        else if (p < 12)  return r_sa[8*(11-p) +: 8];
        else if (p == 12) return lt[15:8];
        else if (p == 13) return lt[7:0];
        else if (p == 14) return 8'h00;
        else if (p == 15) return 8'h01;
        else              return 8'(p - 16);
    endfunction

    function automatic logic [31:0] exp_word(input int idx);
        logic [31:0] w;
        int p;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            p = idx * 4 + j;
            w = {w[23:0], (p < r_len) ? frame_byte(p) : 8'h00};
        end
        return w;
    endfunction

    task automatic start_run(input int len, input int cnt, input bit inj);
        @(negedge clk);
        pkt_len    = 11'(len);
        pkt_count  = 32'(cnt);
        dst_mac    = {16'($urandom), 32'($urandom)};
        src_mac    = {16'($urandom), 32'($urandom)};
        inject_err = inj;
        start      = 1'b1;
        stop       = 1'b0;
        ready      = 1'b1;
        r_da  = dst_mac;
        r_sa  = src_mac;
        r_len = (len < 60) ? 60 : (len > 1514) ? 1514 : len;
        r_inj = inj;
    endtask

    // Follow a run cycle by cycle until done, checking every beat against the model.
    task automatic monitor(input int budget, input int rdy_pct, input int stop_frame, input int exp_frames);
        int  cyc = 0, beat = 0, gap = 0, frames = 0, dones = 0, beats = 0, post = 0;
        int  w;
        bit  after_eop = 0, stop_sent = 0, first = 1, ended = 0, fr_err = 0, rdy;
        w = (r_len + 3) / 4;
        while (!ended && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            stop  = 1'b0;
            if (stop_frame > 0 && !stop_sent && frames == stop_frame - 1 && beat == 5) begin
                stop = 1'b1;
                stop_sent = 1;
            end
            rdy   = ($urandom_range(99) < rdy_pct);
            ready = rdy;
            if (first) chk("start_latency", 64'({valid, sop, busy}), 64'(3'b111));
            first = 0;
            if (dones > 0) begin
                chk("quiet_after_done", 64'(valid), 64'(0));
                post++;
                if (post >= 6) ended = 1;
            end else if (valid) begin
                if (beat == 0) begin
                    if (after_eop) chk("ipg", 64'(gap), 64'(IPG));
                    fr_err = INJ && r_inj && (m_sent % 8 == 7);
                end
                chk("busy", 64'(busy), 64'(1));
                chk("data", 64'(data), 64'(exp_word(beat)));
                chk("sop", 64'(sop), 64'(beat == 0));
                chk("eop", 64'(eop), 64'(beat == w - 1));
                chk("empty", 64'(empty), (beat == w - 1) ? 64'((4 - r_len % 4) % 4) : 64'(0));
                chk("error", 64'(error), 64'(fr_err && (beat == w - 1)));
                if (rdy) begin
                    beats++;
                    if (beat == w - 1) begin
                        if (error) err_eops++;
                        beat = 0;
                        frames++;
                        m_sent++;
                        after_eop = 1;
                        gap = 0;
                    end else begin
                        beat++;
                    end
                end
            end else begin
                if (beat != 0) chk("no_bubble", 64'(valid), 64'(1));
                if (done) begin
                    dones++;
                    chk("done_gap", 64'(gap), 64'(IPG));
                    chk("done_busy", 64'(busy), 64'(0));
                    chk("done_frames", 64'(frames), 64'(exp_frames));
                end
                gap++;
            end
        end
        chk("run_finished", 64'(ended), 64'(1));
        chk("beat_total", 64'(beats), 64'(exp_frames * w));
        chk("sent_count", 64'(sent_count), 64'(32'(m_sent)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_sent = 0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; inject_err = 1'b0; ready = 1'b1;
        pkt_count = '0; pkt_len = '0; dst_mac = '0; src_mac = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_sop", 64'(sop), 64'(0));
        chk("rst_eop", 64'(eop), 64'(0));
        chk("rst_data", 64'(data), 64'(0));
        chk("rst_empty", 64'(empty), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sent", 64'(sent_count), 64'(0));
        rst_n = 1'b1;

        // Single 64-byte frame, then length edge cases.
        start_run(64, 1, 0);   monitor(2000, 100, 0, 1);
        start_run(61, 1, 0);   monitor(2000, 100, 0, 1);
        start_run(30, 1, 0);   monitor(2000, 100, 0, 1);
        start_run(2000, 1, 0); monitor(4000, 100, 0, 1);

        // start and stop together in IDLE: nothing happens.
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        chk("startstop_valid", 64'(valid), 64'(0));
        chk("startstop_busy", 64'(busy), 64'(0));
        @(negedge clk);
        chk("startstop_valid2", 64'(valid), 64'(0));

        // Three frames with random backpressure.
        start_run(int'($urandom_range(40, 300)), 3, 0);
        monitor(20000, 50, 0, 3);

        // Continuous run stopped during frame 5.
        start_run(int'($urandom_range(60, 200)), 0, 0);
        monitor(20000, 80, 5, 5);

        // Asynchronous reset in the middle of payload.
        start_run(200, 1, 0);
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(valid), 64'(0));
        chk("arst_sop", 64'(sop), 64'(0));
        chk("arst_data", 64'(data), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_sent", 64'(sent_count), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_sent = 0;
        start_run(64, 1, 0); monitor(2000, 100, 0, 1);

        // Error injection over 16 frames from a fresh count.
        do_reset();
        err_eops = 0;
        start_run(int'($urandom_range(60, 100)), 16, 1);
        monitor(20000, 100, 0, 16);
        chk("err_eop_count", 64'(err_eops), INJ ? 64'(2) : 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
